// File: rtl/fpu_pkg.sv
// Shared types and encodings for the parametrised floating-point add/sub unit.
package fpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ALIGN  = 3'd1,
        S_ADDSUB = 3'd2,
        S_NORM   = 3'd3,
        S_ROUND  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;

    localparam logic [3:0] STAT_EXACT   = 4'b0001;
    localparam logic [3:0] STAT_INEXACT = 4'b0010;
    localparam logic [3:0] STAT_OVF     = 4'b0100;
    localparam logic [3:0] STAT_UNF     = 4'b1000;

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter; an all-zero input returns IN_W.
module fpu_lzc #(
    parameter int unsigned IN_W  = 28,
    parameter int unsigned CNT_W = $clog2(IN_W + 1)
) (
    input  logic [IN_W-1:0]  i_data,
    output logic [CNT_W-1:0] o_lzc_c
);

    logic w_found;

    always_comb begin
        o_lzc_c = CNT_W'(IN_W);
        w_found = 1'b0;
        for (int i = IN_W - 1; i >= 0; i--) begin
            if (!w_found && i_data[i]) begin
                o_lzc_c = CNT_W'(IN_W - 1 - i);
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_param.sv
// Multi-cycle floating-point adder/subtractor with parametrised exponent and
// mantissa widths; fixed IDLE-ALIGN-ADDSUB-NORM-ROUND-DONE sequence.
module fpu_param
    import fpu_pkg::*;
#(
    parameter int unsigned EXP_W = 7,
    parameter int unsigned MAN_W = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic [1:0]             op,
    output logic                   busy,
    output logic                   done,
    output logic [EXP_W+MAN_W:0]   data_out,
    output logic [3:0]             status_out
);

    localparam int unsigned W      = 1 + EXP_W + MAN_W;
    localparam int unsigned SIG_W  = MAN_W + 1;
    localparam int unsigned PATH_W = SIG_W + 3;
    localparam int unsigned SUM_W  = PATH_W + 1;
    localparam int unsigned CNT_W  = $clog2(PATH_W + 1);
    localparam int unsigned EXPS_W = EXP_W + 3;

    localparam logic signed [EXPS_W-1:0] EXP_ONES_S = EXPS_W'((1 << EXP_W) - 1);
    localparam logic signed [EXPS_W-1:0] EXP_ONE_S  = EXPS_W'(1);

    state_t                    r_state;
    logic [W-1:0]              r_a;
    logic [W-1:0]              r_b;
    logic                      r_rsvd;
    logic                      r_inf;
    logic                      r_inf_sign;
    logic                      r_sign;
    logic                      r_eff_sub;
    logic                      r_zero;
    logic signed [EXPS_W-1:0]  r_exp;
    logic [PATH_W-1:0]         r_big;
    logic [PATH_W-1:0]         r_small;
    logic [SUM_W-1:0]          r_sum;
    logic [PATH_W-1:0]         r_norm;
    logic                      r_busy;
    logic                      r_done;
    logic [W-1:0]              r_data;
    logic [3:0]                r_status;

    // Alignment: order operands by magnitude and shift the smaller one with sticky.
    logic [EXP_W-1:0]  w_exp_a, w_exp_b, w_exp_big, w_exp_small, w_diff;
    logic [SIG_W-1:0]  w_sig_a, w_sig_b, w_sig_big, w_sig_small;
    logic              w_a_ge_b, w_sign_big, w_inf_a, w_inf_b;
    logic [PATH_W-1:0] w_path, w_lost, w_small_al;

    always_comb begin
        w_exp_a     = r_a[MAN_W +: EXP_W];
        w_exp_b     = r_b[MAN_W +: EXP_W];
        w_sig_a     = (w_exp_a == '0) ? '0 : {1'b1, r_a[MAN_W-1:0]};
        w_sig_b     = (w_exp_b == '0) ? '0 : {1'b1, r_b[MAN_W-1:0]};
        w_inf_a     = &w_exp_a;
        w_inf_b     = &w_exp_b;
        w_a_ge_b    = {w_exp_a, w_sig_a} >= {w_exp_b, w_sig_b};
        w_exp_big   = w_a_ge_b ? w_exp_a : w_exp_b;
        w_exp_small = w_a_ge_b ? w_exp_b : w_exp_a;
        w_sig_big   = w_a_ge_b ? w_sig_a : w_sig_b;
        w_sig_small = w_a_ge_b ? w_sig_b : w_sig_a;
        w_sign_big  = w_a_ge_b ? r_a[W-1] : r_b[W-1];
        w_diff      = w_exp_big - w_exp_small;
        w_path      = {w_sig_small, 3'b000};
        w_lost      = '0;
        if (32'(w_diff) >= MAN_W + 3) begin
            w_small_al = {{(PATH_W-1){1'b0}}, |w_path};
        end else begin
            w_lost     = ~({PATH_W{1'b1}} << w_diff);
            w_small_al = (w_path >> w_diff) | {{(PATH_W-1){1'b0}}, |(w_path & w_lost)};
        end
    end

    logic [CNT_W-1:0] w_lzc;

    fpu_lzc #(
        .IN_W  (PATH_W),
        .CNT_W (CNT_W)
    ) u_lzc (
        .i_data  (r_sum[PATH_W-1:0]),
        .o_lzc_c (w_lzc)
    );

    // Rounding (nearest, ties to even) and final result/status selection.
    logic                     w_rup, w_carry, w_inexact;
    logic [SIG_W:0]           w_sig_r;
    logic signed [EXPS_W-1:0] w_exp_f;
    logic [MAN_W-1:0]         w_man_f;
    logic [W-1:0]             w_res;
    logic [3:0]               w_stat;

    always_comb begin
        w_rup     = r_norm[2] & (r_norm[1] | r_norm[0] | r_norm[3]);
        w_sig_r   = {1'b0, r_norm[PATH_W-1:3]} + (SIG_W+1)'(w_rup);
        w_carry   = w_sig_r[SIG_W];
        w_exp_f   = r_exp + EXPS_W'(w_carry);
        w_man_f   = w_carry ? w_sig_r[MAN_W:1] : w_sig_r[MAN_W-1:0];
        w_inexact = |r_norm[2:0];
        w_res     = '0;
        w_stat    = STAT_EXACT;
        if (r_rsvd) begin
            w_stat = STAT_UNF;
        end else if (r_inf) begin
            w_res  = {r_inf_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_stat = STAT_OVF;
        end else if (r_zero) begin
            w_stat = STAT_EXACT;
        end else if (w_exp_f >= EXP_ONES_S) begin
            w_res  = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_stat = STAT_OVF;
        end else if (w_exp_f < EXP_ONE_S) begin
            w_stat = STAT_UNF;
        end else begin
            w_res  = {r_sign, w_exp_f[EXP_W-1:0], w_man_f};
            w_stat = w_inexact ? STAT_INEXACT : STAT_EXACT;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_rsvd     <= 1'b0;
            r_inf      <= 1'b0;
            r_inf_sign <= 1'b0;
            r_sign     <= 1'b0;
            r_eff_sub  <= 1'b0;
            r_zero     <= 1'b0;
            r_exp      <= '0;
            r_big      <= '0;
            r_small    <= '0;
            r_sum      <= '0;
            r_norm     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_data     <= '0;
            r_status   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= {b[W-1] ^ (op == OP_SUB), b[W-2:0]};
                        r_rsvd  <= op[1];
                        r_busy  <= 1'b1;
                        r_state <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    r_inf      <= w_inf_a | w_inf_b;
                    r_inf_sign <= w_inf_a ? r_a[W-1] : r_b[W-1];
                    r_sign     <= w_sign_big;
                    r_eff_sub  <= r_a[W-1] ^ r_b[W-1];
                    r_exp      <= EXPS_W'(w_exp_big);
                    r_big      <= {w_sig_big, 3'b000};
                    r_small    <= w_small_al;
                    r_state    <= S_ADDSUB;
                end
                S_ADDSUB: begin
                    r_sum   <= r_eff_sub ? ({1'b0, r_big} - {1'b0, r_small})
                                         : ({1'b0, r_big} + {1'b0, r_small});
                    r_state <= S_NORM;
                end
                S_NORM: begin
                    r_zero <= (r_sum == '0);
                    if (r_sum[PATH_W]) begin
                        r_norm <= {r_sum[PATH_W:2], |r_sum[1:0]};
                        r_exp  <= r_exp + EXPS_W'(1);
                    end else begin
                        r_norm <= r_sum[PATH_W-1:0] << w_lzc;
                        r_exp  <= r_exp - EXPS_W'(w_lzc);
                    end
                    r_state <= S_ROUND;
                end
                S_ROUND: begin
                    r_data   <= w_res;
                    r_status <= w_stat;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign data_out   = r_data;
    assign status_out = r_status;

endmodule

// File: tb/tb_fpu_param.sv
// Directed self-checking bench for fpu_param at EXP_W=7, MAN_W=24.
module tb_fpu_param;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic        busy;
    logic        done;
    logic [31:0] data_out;
    logic [3:0]  status_out;

    int checks = 0;
    int errors = 0;

    fpu_param #(
        .EXP_W (7),
        .MAN_W (24)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .a          (a),
        .b          (b),
        .op         (op),
        .busy       (busy),
        .done       (done),
        .data_out   (data_out),
        .status_out (status_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Launch one operation and check result, status, latency and return to idle.
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tbv, input logic [1:0] top,
                         input logic [31:0] ed, input logic [3:0] es, input string tag);
        int lat;
        @(negedge clk);
        a = ta; b = tbv; op = top; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        chk(32'(busy), 32'd1, {tag, "_busy"});
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk(32'(lat), 32'd5, {tag, "_latency"});
        chk(data_out, ed, {tag, "_data"});
        chk(32'(status_out), 32'(es), {tag, "_status"});
        @(posedge clk); #1;
        chk(32'(done), 32'd0, {tag, "_done_pulse"});
        chk(32'(busy), 32'd0, {tag, "_busy_clear"});
    endtask

    initial begin
        int d0, d1, d2, ndone;
        reset = 1'b0; start = 1'b0; a = '0; b = '0; op = 2'b00;
        #23;
        chk(32'(busy), 32'd0, "rst_busy");
        chk(32'(done), 32'd0, "rst_done");
        chk(data_out, 32'h0, "rst_data");
        chk(32'(status_out), 32'h0, "rst_status");
        @(negedge clk);
        reset = 1'b1;

        do_op(32'h3F000000, 32'h3F000000, 2'b00, 32'h40000000, 4'b0001, "add_1p1");
        do_op(32'h40800000, 32'h3F000000, 2'b01, 32'h40000000, 4'b0001, "sub_3m1");
        do_op(32'h40800000, 32'h3F000000, 2'b00, 32'h41000000, 4'b0001, "add_3p1");
        do_op(32'h3F000000, 32'h26000000, 2'b00, 32'h3F000000, 4'b0010, "tie_even");
        do_op(32'h3F000001, 32'h26000000, 2'b00, 32'h3F000002, 4'b0010, "tie_odd");
        do_op(32'h3F000000, 32'h26800000, 2'b00, 32'h3F000001, 4'b0010, "above_half");
        do_op(32'h3F000000, 32'h01000000, 2'b00, 32'h3F000000, 4'b0010, "sticky_only");
        do_op(32'h7EFFFFFF, 32'h7EFFFFFF, 2'b00, 32'h7F000000, 4'b0100, "overflow");
        do_op(32'h7F000000, 32'h3F000000, 2'b00, 32'h7F000000, 4'b0100, "inf_a");
        do_op(32'h3F000000, 32'hFF000000, 2'b01, 32'h7F000000, 4'b0100, "inf_b_sub");
        do_op(32'h01800000, 32'h01000000, 2'b01, 32'h00000000, 4'b1000, "underflow");
        do_op(32'h3F000000, 32'h3F000000, 2'b01, 32'h00000000, 4'b0001, "sub_equal");
        do_op(32'h3F000000, 32'h40800000, 2'b01, 32'hC0000000, 4'b0001, "sub_negative");
        do_op(32'h00000000, 32'h00000000, 2'b00, 32'h00000000, 4'b0001, "zero_zero");
        do_op(32'h3F000000, 32'h3F000000, 2'b10, 32'h00000000, 4'b1000, "reserved_op");
        do_op(32'hBF000000, 32'h3F000000, 2'b00, 32'h00000000, 4'b0001, "cancel_pos_zero");
        do_op(32'h00000000, 32'hBF800000, 2'b00, 32'hBF800000, 4'b0001, "zero_plus_neg");

        // Start held high: one accept per six-cycle slot.
        d0 = 0; d1 = 0; d2 = 0; ndone = 0;
        @(negedge clk);
        a = 32'h3F000000; b = 32'h3F000000; op = 2'b00; start = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(posedge clk); #1;
            if (k == 6) chk(32'(busy), 32'd0, "cont_idle_gap");
            if (k == 7) chk(32'(busy), 32'd1, "cont_reaccept");
            if (done) begin
                if (ndone == 0) d0 = k;
                if (ndone == 1) d1 = k;
                if (ndone == 2) d2 = k;
                ndone++;
            end
        end
        @(negedge clk);
        start = 1'b0;
        chk(32'(ndone), 32'd3, "cont_done_count");
        chk(32'(d0), 32'd5, "cont_first_done");
        chk(32'(d1 - d0), 32'd6, "cont_slot1");
        chk(32'(d2 - d1), 32'd6, "cont_slot2");
        @(posedge clk); #1;
        chk(32'(busy), 32'd0, "cont_stopped");

        // Reset dropped during ALIGN aborts the operation.
        @(negedge clk);
        a = 32'h40800000; b = 32'h3F000000; op = 2'b00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk(32'(busy), 32'd1, "abort_accepted");
        #2 reset = 1'b0;
        #1;
        chk(32'(busy), 32'd0, "abort_busy");
        chk(32'(done), 32'd0, "abort_done");
        chk(data_out, 32'h0, "abort_data");
        chk(32'(status_out), 32'h0, "abort_status");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk(32'(ndone), 32'd0, "abort_no_done");
        chk(data_out, 32'h0, "abort_data_held");

        do_op(32'h40800000, 32'h3F000000, 2'b01, 32'h40000000, 4'b0001, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
